// File: rtl/sr_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sr_ram_arbiter
// Description : Round-robin arbiter sharing one data RAM among sr_cpu cores,
//               with a per-core store queue and a blocking load path.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_ram_arbiter #(
    parameter int CORE_COUNT = 4,
    parameter int RAM_AW     = 10,
    parameter int SQ_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3*CORE_COUNT-1:0] core_instr,
    input  logic [32*CORE_COUNT-1:0] core_addr,
    input  logic [32*CORE_COUNT-1:0] core_wdata,
    output logic [31:0]             data_to_cpu,
    output logic [CORE_COUNT-1:0]   data_received,
    output logic [RAM_AW-1:0]       ram_addr,
    output logic [31:0]             ram_wdata,
    output logic                    ram_we,
    output logic                    ram_re,
    input  logic [31:0]             ram_rdata,
    output logic [CORE_COUNT-1:0]   store_overflow
);

    // AGU command encoding; any other value means idle.
    localparam logic [2:0] c_AGU_LOAD  = 3'd1;
    localparam logic [2:0] c_AGU_STORE = 3'd2;
    localparam int         c_PW        = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
    localparam int         c_GW        = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_GW-1:0]     r_last;
    logic [c_GW-1:0]     r_grant;
    logic [c_GW-1:0]     w_sel;
    logic [c_GW:0]       w_idx;
    logic                w_sel_vld;
    logic                w_sel_store;
    logic [31:0]         r_hold;

    logic [RAM_AW-1:0]   r_sq_addr [CORE_COUNT][SQ_DEPTH];
    logic [31:0]         r_sq_data [CORE_COUNT][SQ_DEPTH];
    logic [c_PW-1:0]     r_wr_ptr  [CORE_COUNT];
    logic [c_PW-1:0]     r_rd_ptr  [CORE_COUNT];
    logic [c_PW:0]       r_count   [CORE_COUNT];
    logic                r_ovf     [CORE_COUNT];
    logic [31:0]         w_core_addr [CORE_COUNT];

    logic [CORE_COUNT-1:0] w_store, w_load, w_full, w_empty, w_req, w_push, w_pop;

    genvar gi;
    generate
        for (gi = 0; gi < CORE_COUNT; gi++) begin : g_core
            assign w_core_addr[gi] = core_addr[32*gi +: 32];
            assign w_store[gi]     = core_instr[3*gi +: 3] == c_AGU_STORE;
            assign w_load[gi]      = core_instr[3*gi +: 3] == c_AGU_LOAD;
            assign w_full[gi]      = r_count[gi] == (c_PW+1)'(SQ_DEPTH);
            assign w_empty[gi]     = r_count[gi] == '0;
            // A non-empty queue always wins over this core's own load.
            assign w_req[gi]       = !w_empty[gi] || w_load[gi];
            assign w_pop[gi]       = ram_we && (w_sel == c_GW'(gi));
            assign w_push[gi]      = w_store[gi] && (!w_full[gi] || w_pop[gi]);
            assign store_overflow[gi] = r_ovf[gi];

            always_ff @(posedge clk) begin
                if (w_push[gi]) begin
                    r_sq_addr[gi][r_wr_ptr[gi]] <= w_core_addr[gi][RAM_AW+1:2];
                    r_sq_data[gi][r_wr_ptr[gi]] <= core_wdata[32*gi +: 32];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wr_ptr[gi] <= '0;
                    r_rd_ptr[gi] <= '0;
                    r_count[gi]  <= '0;
                    r_ovf[gi]    <= 1'b0;
                end else begin
                    if (w_push[gi]) r_wr_ptr[gi] <= r_wr_ptr[gi] + 1'b1;
                    if (w_pop[gi])  r_rd_ptr[gi] <= r_rd_ptr[gi] + 1'b1;
                    r_count[gi] <= r_count[gi] + (c_PW+1)'(w_push[gi]) - (c_PW+1)'(w_pop[gi]);
                    if (w_store[gi] && w_full[gi] && !w_pop[gi]) r_ovf[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Round-robin search starting one past the last granted core.
    always_comb begin
        w_sel     = '0;
        w_sel_vld = 1'b0;
        w_idx     = '0;
        for (int k = CORE_COUNT; k >= 1; k--) begin
            w_idx = {1'b0, r_last} + (c_GW+1)'(k);
            if (w_idx >= (c_GW+1)'(CORE_COUNT)) w_idx = w_idx - (c_GW+1)'(CORE_COUNT);
            if (w_req[w_idx[c_GW-1:0]]) begin
                w_sel     = w_idx[c_GW-1:0];
                w_sel_vld = 1'b1;
            end
        end
        w_sel_store = !w_empty[w_sel];
    end

    always_comb begin
        w_state_nxt = r_state;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        case (r_state)
            ARB: begin
                if (w_sel_vld && rst_n) begin
                    if (w_sel_store) begin
                        ram_we    = 1'b1;
                        ram_addr  = r_sq_addr[w_sel][r_rd_ptr[w_sel]];
                        ram_wdata = r_sq_data[w_sel][r_rd_ptr[w_sel]];
                    end else begin
                        ram_re      = 1'b1;
                        ram_addr    = w_core_addr[w_sel][RAM_AW+1:2];
                        w_state_nxt = READ;
                    end
                end
            end
            READ:    w_state_nxt = RESP;
            RESP:    w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB;
            r_last  <= c_GW'(CORE_COUNT - 1);
            r_grant <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (ram_we || ram_re) r_last  <= w_sel;
            if (ram_re)           r_grant <= w_sel;
            if (r_state == READ)  r_hold  <= ram_rdata;
        end
    end

    assign data_to_cpu = r_hold;

    always_comb begin
        data_received = '0;
        if (r_state == RESP) data_received[r_grant] = 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_ram_arbiter
// Description : Directed and randomized bench for sr_ram_arbiter against a
//               queue-based behavioural model of the shared-RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_ram_arbiter;

    localparam int N = 4;
    localparam int AGU_IDLE  = 0;
    localparam int AGU_LOAD  = 1;
    localparam int AGU_STORE = 2;

    logic            clk;
    logic            rst_n;
    logic [3*N-1:0]  core_instr;
    logic [32*N-1:0] core_addr;
    logic [32*N-1:0] core_wdata;
    logic [31:0]     data_to_cpu;
    logic [N-1:0]    data_received;
    logic [9:0]      ram_addr;
    logic [31:0]     ram_wdata;
    logic            ram_we;
    logic            ram_re;
    logic [31:0]     ram_rdata;
    logic [N-1:0]    store_overflow;

    sr_ram_arbiter #(.CORE_COUNT(N), .RAM_AW(10), .SQ_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .core_instr(core_instr), .core_addr(core_addr),
        .core_wdata(core_wdata), .data_to_cpu(data_to_cpu), .data_received(data_received),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata), .store_overflow(store_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int a);
        return (a == 4) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h0BADF00D);
    endfunction

    // RAM environment: one-cycle read latency, unwritten words hold init_word.
    logic [31:0] env_mem [1024];
    bit          env_wr  [1024];
    always @(posedge clk) begin
        if (ram_re) ram_rdata <= env_wr[ram_addr] ? env_mem[ram_addr] : init_word(int'(ram_addr));
        if (ram_we) begin
            env_mem[ram_addr] <= ram_wdata;
            env_wr[ram_addr]  <= 1'b1;
        end
    end

    // Behavioural model state.
    int          m_state;   // 0 arbitrating, 1 read in flight, 2 responding
    int          m_last, m_grant, m_laddr;
    logic [31:0] m_dout;
    logic [3:0]  m_ovf;
    logic [3:0]  m_dr;
    logic [31:0] m_mem [1024];
    logic [41:0] m_q [N][$];

    int          instr [N];
    logic [31:0] addr  [N];
    logic [31:0] wdata [N];

    int          n_vec, n_err;
    logic        s_we;
    logic [31:0] s_wdata;
    logic [3:0]  s_dr;
    logic [31:0] wq [$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            core_instr[3*c +: 3]  = 3'(instr[c]);
            core_addr[32*c +: 32] = addr[c];
            core_wdata[32*c +: 32] = wdata[c];
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_last = N - 1; m_grant = 0; m_laddr = 0;
        m_dout = '0; m_ovf = '0; m_dr = '0;
        for (int c = 0; c < N; c++) m_q[c].delete();
    endtask

    task automatic do_reset();
        drive();
        rst_n = 1'b0;
        #1;
        chk("rst_we", {31'd0, ram_we}, 32'd0);
        chk("rst_re", {31'd0, ram_re}, 32'd0);
        chk("rst_addr", {22'd0, ram_addr}, 32'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        chk("rst_drcv", {28'd0, data_received}, 32'd0);
        chk("rst_dout", data_to_cpu, 32'd0);
        chk("rst_ovf", {28'd0, store_overflow}, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: compare all outputs with the model, then advance the model.
    task automatic tick();
        int          sel;
        logic [41:0] head;
        logic [31:0] e_we, e_re, e_addr, e_wd, e_dr;
        drive();
        @(negedge clk);
        sel = -1;
        head = '0;
        if (m_state == 0)
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (sel < 0 && (m_q[c].size() > 0 || instr[c] == AGU_LOAD)) sel = c;
            end
        e_we = 0; e_re = 0; e_addr = 0; e_wd = 0;
        if (sel >= 0) begin
            if (m_q[sel].size() > 0) begin
                head = m_q[sel][0];
                e_we = 1; e_addr = {22'd0, head[41:32]}; e_wd = head[31:0];
            end else begin
                e_re = 1; e_addr = {22'd0, addr[sel][11:2]};
            end
        end
        e_dr = (m_state == 2) ? (32'd1 << m_grant) : 32'd0;
        s_we = ram_we; s_wdata = ram_wdata; s_dr = data_received;
        chk("ram_we", {31'd0, ram_we}, e_we);
        chk("ram_re", {31'd0, ram_re}, e_re);
        chk("ram_addr", {22'd0, ram_addr}, e_addr);
        chk("ram_wdata", ram_wdata, e_wd);
        chk("data_received", {28'd0, data_received}, e_dr);
        chk("data_to_cpu", data_to_cpu, m_dout);
        chk("store_overflow", {28'd0, store_overflow}, {28'd0, m_ovf});
        if (e_we == 1) begin
            m_mem[head[41:32]] = head[31:0];
            void'(m_q[sel].pop_front());
            m_last = sel;
        end
        case (m_state)
            0: if (e_re == 1) begin
                m_grant = sel; m_last = sel; m_laddr = int'(addr[sel][11:2]); m_state = 1;
            end
            1: begin m_dout = m_mem[m_laddr]; m_state = 2; end
            default: m_state = 0;
        endcase
        for (int c = 0; c < N; c++)
            if (instr[c] == AGU_STORE) begin
                if (m_q[c].size() < 4) m_q[c].push_back({addr[c][11:2], wdata[c]});
                else m_ovf[c] = 1'b1;
            end
        m_dr = e_dr[3:0];
        @(posedge clk);
        #1;
    endtask

    // Cores drop their load once the response pulse has been seen.
    task automatic tick_rel();
        tick();
        for (int c = 0; c < N; c++) if (m_dr[c]) instr[c] = AGU_IDLE;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        ram_rdata = '0;
        for (int i = 0; i < 1024; i++) m_mem[i] = init_word(i);
        for (int c = 0; c < N; c++) begin instr[c] = AGU_IDLE; addr[c] = '0; wdata[c] = '0; end
        do_reset();
        repeat (2) tick();

        // Single load returning a preloaded word.
        instr[1] = AGU_LOAD; addr[1] = 32'h10;
        repeat (3) tick_rel();
        chk("load_c1_data", data_to_cpu, 32'hDEADBEEF);
        tick();

        // Store followed by a load of the same address.
        instr[0] = AGU_STORE; addr[0] = 32'h20; wdata[0] = 32'h12345678;
        tick();
        instr[0] = AGU_LOAD;
        repeat (4) tick_rel();
        chk("st_ld_data", data_to_cpu, 32'h12345678);

        // Four simultaneous loads after reset.
        do_reset();
        for (int c = 0; c < N; c++) begin instr[c] = AGU_LOAD; addr[c] = 32'h100 + 32'(16 * c); end
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick_rel();
            chk("grant_order", {28'd0, s_dr}, (cyc % 3 == 2) ? (32'd1 << (cyc / 3)) : 32'd0);
        end

        // Store burst into core 2 while loads hold the RAM.
        do_reset();
        wq.delete();
        instr[0] = AGU_LOAD; addr[0] = 32'h40;
        tick_rel();
        instr[1] = AGU_LOAD; addr[1] = 32'h44;
        for (int k = 0; k < 5; k++) begin
            instr[2] = AGU_STORE; addr[2] = 32'h30 + 32'(4 * k); wdata[2] = 32'hC0DE0000 + 32'(k);
            tick_rel();
            if (s_we) wq.push_back(s_wdata);
        end
        instr[2] = AGU_IDLE;
        repeat (6) begin
            tick_rel();
            if (s_we) wq.push_back(s_wdata);
        end
        chk("sq_write_count", 32'(wq.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < wq.size()) chk("sq_write_order", wq[k], 32'hC0DE0000 + 32'(k));
        chk("sq_overflow", {28'd0, store_overflow}, 32'h4);
        repeat (3) tick();
        chk("sq_overflow_sticky", {28'd0, store_overflow}, 32'h4);

        // Reset while a load is in READ; the load is retried after release.
        instr[2] = AGU_LOAD; addr[2] = 32'h50;
        tick();
        do_reset();
        tick_rel();
        tick_rel();
        tick_rel();
        chk("retry_pulse", {28'd0, s_dr}, 32'h4);

        // Randomized traffic against the model.
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            tick();
            for (int c = 0; c < N; c++) begin
                int r;
                if (instr[c] == AGU_LOAD && !m_dr[c]) continue;
                r = int'($urandom_range(0, 9));
                instr[c] = (r < 4) ? AGU_IDLE : (r < 7) ? AGU_STORE : AGU_LOAD;
                addr[c]  = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
                wdata[c] = $urandom;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr_ram_arbiter.md
SR_RAM_ARBITER -- requirements
Module: sr_ram_arbiter

Interface
REQ-001 Parameter CORE_COUNT, default 4; number of sr_cpu cores sharing one data RAM.
REQ-002 Parameter RAM_AW, default 10; RAM word-address width.
REQ-003 Parameter SQ_DEPTH, default 4, power of two; per-core store-queue depth.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 core_instr  in  3*CORE_COUNT  per-core aguInstructionOut; slice i = [3i+2:3i]; values AGU_IDLE, AGU_LOAD, AGU_STORE.
REQ-007 core_addr  in  32*CORE_COUNT  per-core ramAddress, byte address.
REQ-008 core_wdata  in  32*CORE_COUNT  per-core dataFromCpu.
REQ-009 data_to_cpu  out  32  load data, broadcast to all cores' dataToCpu.
REQ-010 data_received  out  CORE_COUNT  per-core dataReceived pulse.
REQ-011 ram_addr  out  RAM_AW  word address, equal to byte address bits [RAM_AW+1:2].
REQ-012 ram_wdata  out  32  write data.
REQ-013 ram_we, ram_re  out  1 each  write / read strobes.
REQ-014 ram_rdata  in  32  RAM read data, valid exactly one cycle after ram_re.
REQ-015 store_overflow  out  CORE_COUNT  sticky flag per core: a store was dropped.

Function
REQ-016 A store is captured into core i's store queue in every cycle in which core i's core_instr slice equals AGU_STORE; the captured entry holds {word address, wdata}; the core is never stalled for a store.
REQ-017 A store arriving at a full queue is dropped and sets store_overflow[i]; a push and a pop in the same cycle on a full queue is accepted, and the occupancy stays unchanged.
REQ-018 A load from core i is pending while core_instr slice i equals AGU_LOAD; the core holds instr and address stable until data_received[i].
REQ-019 Core i requests service if its store queue is non-empty, or if a load is pending and its queue is empty; its own stores always precede its load.
REQ-020 FSM states: ARB, READ, RESP.
REQ-021 ARB: select the requesting core found first in round-robin order, starting at last_grant+1 mod CORE_COUNT; if none, drive all RAM strobes low and stay in ARB.
REQ-022 ARB store service: in the same cycle, ram_we=1 with the queue head's address and data, pop the head, set last_grant=i, and stay in ARB; one store per cycle.
REQ-023 ARB load service: in the same cycle, ram_re=1 and ram_addr=core_addr slice i [RAM_AW+1:2], latch the granted index, set last_grant=i, and go to READ.
REQ-024 READ: register ram_rdata into the data holding register; strobes low; go to RESP.
REQ-025 RESP: data_received[granted]=1 for exactly this cycle, data_to_cpu = holding register; go to ARB. A load in ARB on the cycle after RESP is a new load.
REQ-026 Load latency from grant is 2 cycles (grant at t, data_received at t+2); at most one bit of data_received is high in any cycle.
REQ-027 The RAM strobes ram_we and ram_re are never both high; in any cycle with no strobe, ram_addr and ram_wdata are 0.
REQ-028 data_to_cpu holds its last value outside RESP.
REQ-029 Address bits above RAM_AW+1 and bits [1:0] are ignored; there is no alignment check and no wrap error.
REQ-030 A store capture and a RAM write for the same core in the same cycle are both allowed (REQ-017).

Reset
REQ-031 While rst_n=0, immediately: FSM in ARB, all queues empty, last_grant=CORE_COUNT-1, holding register 0, data_to_cpu 0, data_received 0, ram_we/ram_re 0, ram_addr/ram_wdata 0, store_overflow 0.
REQ-032 Reset during READ or RESP abandons the in-flight load with no data_received pulse; the core re-requests after release.
REQ-033 The first grant after reset goes to the lowest-index requester.

Verification
REQ-034 Core 1 LOAD to 0x10, RAM word 4 = 0xDEADBEEF -> ram_re with ram_addr=4 at t, data_received=4'b0010 for one cycle at t+2, data_to_cpu=0xDEADBEEF.
REQ-035 Core 0 STORE 0x12345678 to 0x20, then immediate LOAD 0x20 -> ram_we (addr 8) precedes ram_re, and the load returns 0x12345678.
REQ-036 All 4 cores LOAD at once after reset -> grants in order 0,1,2,3, every 3 cycles; four single non-overlapping data_received pulses.
REQ-037 Core 2 issues 5 consecutive STOREs while core 0's load owns the RAM, SQ_DEPTH=4 -> 4 writes issued in order, fifth dropped, store_overflow=4'b0100 until reset.
REQ-038 rst_n low during READ -> all outputs 0 immediately; after release, the pending load completes normally with a 2-cycle latency.
